// File: rtl/fa_bist_ctrl.sv
// BIST controller for the full-adder CUT: pattern source, 4-bit MISR compactor, golden-signature compare.
// Define FA_BIST_EXHAUSTIVE_EN for an 8-pattern binary-count sequence instead of the 7-state LFSR.
module fa_bist_ctrl #(
   parameter logic [2:0] SEED   = 3'b001,
`ifdef FA_BIST_EXHAUSTIVE_EN
   parameter logic [3:0] GOLDEN = 4'b1010
`else
   parameter logic [3:0] GOLDEN = 4'b0110
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       cut_a,
   output logic       cut_b,
   output logic       cut_cin,
   input  logic       cut_sum,
   input  logic       cut_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] signature
);

`ifdef FA_BIST_EXHAUSTIVE_EN
   localparam int         N_PAT    = 8;
   localparam logic [2:0] PAT_INIT = 3'b000;
`else
   localparam int         N_PAT    = 7;
   localparam logic [2:0] PAT_INIT = SEED;
`endif
   localparam logic [2:0] LAST_CNT = 3'(N_PAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_pat;
   logic [2:0] r_cnt;
   logic [3:0] r_misr;
   logic       r_pass;
   logic [2:0] w_pat_next;
   logic [3:0] w_misr_next;
   logic       w_last;
   logic       w_launch;
   logic       w_capture;

   function automatic logic [2:0] next_pattern(input logic [2:0] p);
`ifdef FA_BIST_EXHAUSTIVE_EN
      return p + 3'd1;
`else
      return {p[1:0], p[2] ^ p[1]};
`endif
   endfunction

   function automatic logic [3:0] misr_step(input logic [3:0] m, input logic cout, input logic sum);
      logic [3:0] shifted;
      shifted = {m[2:0], m[3] ^ m[2]};
      return shifted ^ {2'b00, cout, sum};
   endfunction

   assign w_pat_next  = next_pattern(r_pat);
   assign w_misr_next = misr_step(r_misr, cut_cout, cut_sum);
   assign w_last      = (r_cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_capture    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_launch     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            w_capture = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Every RUN edge absorbs the response to the pattern currently on the CUT, then advances it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pat  <= PAT_INIT;
         r_cnt  <= 3'd0;
         r_misr <= 4'd0;
         r_pass <= 1'b0;
      end else if (w_launch) begin
         r_pat  <= PAT_INIT;
         r_cnt  <= 3'd0;
         r_misr <= 4'd0;
         r_pass <= 1'b0;
      end else if (w_capture) begin
         r_pat  <= w_pat_next;
         r_cnt  <= r_cnt + 3'd1;
         r_misr <= w_misr_next;
         if (w_last) begin
            r_pass <= (w_misr_next == GOLDEN);
         end
      end
   end

   assign {cut_a, cut_b, cut_cin} = (r_state == S_RUN) ? r_pat : 3'b000;
   assign pass      = r_pass;
   assign signature = r_misr;

endmodule

// File: doc/fa_bist_ctrl.md
# fa_bist_ctrl

Built-in self-test controller for the full-adder circuit under test (CUT). It sits directly upstream and downstream of the full-adder netlist: it drives the CUT primary inputs `a`, `b` and `Cin` with a pattern sequence, and compacts the CUT primary outputs `sum` and `Cout` into a multiple-input signature register (MISR). At the end of a run it compares the final signature against a golden value and reports pass/fail. Serial fault simulation uses it as the per-fault test harness.

## Interface
Parameters:
- `SEED`, 3'b001: LFSR seed, i.e. the first pattern in LFSR mode. Must be nonzero.
- `GOLDEN`, 4'b0110 (4'b1010 when `FA_BIST_EXHAUSTIVE_EN` is defined): expected fault-free signature.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `cut_a`  out  1  pattern bit 2, drives CUT `a`.
- `cut_b`  out  1  pattern bit 1, drives CUT `b`.
- `cut_cin`  out  1  pattern bit 0, drives CUT `Cin`.
- `cut_sum`  in  1  CUT `sum` response.
- `cut_cout`  in  1  CUT `Cout` response.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  final signature == `GOLDEN`. Held until the next start or reset.
- `signature`  out  4  MISR contents.

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: after N_PAT captures → DONE.
  - DONE: → IDLE unconditionally.
- Pattern register `pat[2:0]` drives `{cut_a,cut_b,cut_cin}` in RUN. Outputs are 3'b000 in IDLE and DONE.
- LFSR mode (default), N_PAT=7:
  - Update rule: `pat_next = {pat[1:0], pat[2]^pat[1]}`.
  - From seed 001 the sequence is 001,010,101,011,111,110,100.
- MISR, 4 bits, cleared on start:
  - `shifted = {m[2:0], m[3]^m[2]}`.
  - `m_next = shifted ^ {2'b00, cut_cout, cut_sum}`.
- Capture: on every RUN clock edge the MISR absorbs the CUT response to the current `pat`, `pat` advances, and the capture counter increments.
- On the N_PAT-th capture edge:
  - state moves to DONE.
  - `pass <= (m_next == GOLDEN)`.
- The CUT is combinational. Its response is sampled in the same cycle the pattern is applied.
- `start` in RUN or DONE is ignored. There is no abort except `rst`.
- `signature` holds its final value through IDLE until the next start.

## Timing
- Reset values:
  - state = IDLE.
  - `pat` = SEED (3'b000 in exhaustive mode).
  - MISR = 0.
  - `busy`, `done`, `pass` = 0.
  - `cut_*` = 0.
- Run timeline (start sampled high in IDLE at edge E0):
  - E0: `pat` ← first pattern, MISR ← 0, `pass` ← 0, state ← RUN.
  - Captures happen at edges E1..E(N_PAT).
  - `done` is high for exactly the one cycle between E(N_PAT) and E(N_PAT+1). `pass` is valid from that same cycle.
- Back-to-back runs: `start` held high re-launches at the first IDLE edge after DONE.
- `rst` during RUN: IDLE and all reset values at the next edge. No `done` pulse is produced.
- `rst` and `start` asserted together: `rst` wins.

## Configuration
- `FA_BIST_EXHAUSTIVE_EN` defined:
  - `pat` is a 3-bit binary up-counter from 000 to 111, N_PAT=8.
  - `GOLDEN` default is 4'b1010.
- Not defined: LFSR mode as above, N_PAT=7, `GOLDEN` default 4'b0110.
- The MISR, FSM and handshake are identical in both builds.

## Test plan
- Fault-free CUT, LFSR mode, `start` pulsed:
  - `busy` is high for 7 cycles.
  - `cut_*` steps through 001,010,101,011,111,110,100.
  - `done` pulses once, `signature`=4'b0110, `pass`=1.
- `cut_cout` forced stuck-at-0, LFSR mode: `signature`=4'b1110, `pass`=0, `done` pulses once.
- `FA_BIST_EXHAUSTIVE_EN` build, fault-free CUT:
  - `busy` is high for 8 cycles over patterns 000..111.
  - `signature`=4'b1010, `pass`=1.
- `rst` asserted on the 4th RUN cycle:
  - Next cycle shows state IDLE, `busy`=0, `signature`=0, `cut_*`=000.
  - No `done` pulse follows.
- `start` re-pulsed mid-run: ignored; the run completes with signature 4'b0110. `start` held high continuously gives two consecutive runs, each with a `done` pulse and `pass`=1.
